// File: rtl/li_reg_multi.sv
// Latency-insensitive register with a DEPTH-token queue fanned out to READERS consumers.
// The head token retires only once every reader has taken it; writes resolve against the last value.
module li_reg_multi #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   INIT    = {WIDTH{1'b0}},
    parameter int                 DEPTH   = 2,
    parameter int                 READERS = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [WIDTH-1:0]             IN_WRITE,
    input  logic                         IN_WRITE_VALID,
    output logic                         IN_WRITE_CONSUMED,
    input  logic                         IN_EN_WRITE,
    input  logic                         IN_EN_WRITE_VALID,
    output logic                         IN_EN_WRITE_CONSUMED,
    output logic [WIDTH-1:0]             OUT_READ,
    output logic [READERS-1:0]           OUT_READ_VALID,
    input  logic [READERS-1:0]           OUT_READ_CONSUMED,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [PW-1:0]      head_r;
    logic [PW-1:0]      tail_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   last_data_r;
    logic [READERS-1:0] done_r;

    logic               inp_valid_s;
    logic               accept_s;
    logic               enq_s;
    logic               not_empty_s;
    logic               retire_s;
    logic [WIDTH-1:0]   resolved_s;
    logic [WIDTH-1:0]   read_s;
    logic [READERS-1:0] valid_s;
    logic [READERS-1:0] fire_s;

    // Circular pointers wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Handshake, resolve and retire decisions; acceptance never looks at reader consumes.
    always_comb begin
        inp_valid_s = IN_WRITE_VALID & IN_EN_WRITE_VALID;
        not_empty_s = (count_r != {CW{1'b0}});
        if (inp_valid_s) begin
            accept_s = (count_r < DEPTH_C);
        end else begin
            accept_s = 1'b1;
        end
        enq_s = inp_valid_s & (count_r < DEPTH_C);
        if (IN_EN_WRITE) begin
            resolved_s = IN_WRITE;
        end else begin
            resolved_s = last_data_r;
        end
        if (not_empty_s) begin
            read_s = mem_r[head_r];
        end else begin
            read_s = last_data_r;
        end
        valid_s  = {READERS{not_empty_s}} & ~done_r;
        fire_s   = valid_s & OUT_READ_CONSUMED;
        retire_s = not_empty_s & (&(done_r | fire_s));
    end

    assign IN_WRITE_CONSUMED    = accept_s;
    assign IN_EN_WRITE_CONSUMED = accept_s;
    assign OUT_READ             = read_s;
    assign OUT_READ_VALID       = valid_s;
    assign COUNT                = count_r;

    // Queue storage, pointers, occupancy and per-reader consumed flags.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= INIT;
            end
            head_r      <= {PW{1'b0}};
            tail_r      <= PTR_ONE;
            count_r     <= CNT_ONE;
            last_data_r <= INIT;
            done_r      <= {READERS{1'b0}};
        end else begin
            if (enq_s) begin
                mem_r[tail_r] <= resolved_s;
                last_data_r   <= resolved_s;
                tail_r        <= ptr_inc(tail_r);
            end else begin
                last_data_r   <= last_data_r;
                tail_r        <= tail_r;
            end
            if (retire_s) begin
                head_r <= ptr_inc(head_r);
                done_r <= {READERS{1'b0}};
            end else begin
                head_r <= head_r;
                done_r <= done_r | fire_s;
            end
            case ({enq_s, retire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_li_reg_multi.sv
// Bench for li_reg_multi: directed scenarios then random traffic, checked against a
// token-queue model with per-reader scoreboards of the values each reader must see.
module tb_li_reg_multi;

    localparam int          WIDTH   = 8;
    localparam int          DEPTH   = 4;
    localparam int          READERS = 2;
    localparam logic [7:0]  INIT    = 8'h5A;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] IN_WRITE;
    logic       IN_WRITE_VALID;
    logic       IN_WRITE_CONSUMED;
    logic       IN_EN_WRITE;
    logic       IN_EN_WRITE_VALID;
    logic       IN_EN_WRITE_CONSUMED;
    logic [7:0] OUT_READ;
    logic [1:0] OUT_READ_VALID;
    logic [1:0] OUT_READ_CONSUMED;
    logic [2:0] COUNT;

    li_reg_multi #(.WIDTH(WIDTH), .INIT(INIT), .DEPTH(DEPTH), .READERS(READERS)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_WRITE(IN_WRITE), .IN_WRITE_VALID(IN_WRITE_VALID), .IN_WRITE_CONSUMED(IN_WRITE_CONSUMED),
        .IN_EN_WRITE(IN_EN_WRITE), .IN_EN_WRITE_VALID(IN_EN_WRITE_VALID),
        .IN_EN_WRITE_CONSUMED(IN_EN_WRITE_CONSUMED),
        .OUT_READ(OUT_READ), .OUT_READ_VALID(OUT_READ_VALID), .OUT_READ_CONSUMED(OUT_READ_CONSUMED),
        .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: values held in the register queue (head first), last value,
    // per-reader taken flags, and the queue of values each reader still has to see.
    logic [7:0] tq[$];
    logic [7:0] rq0[$];
    logic [7:0] rq1[$];
    logic [7:0] mlast;
    logic [1:0] mdone;
    bit         init_done = 1'b0;
    bit         pend = 1'b0;
    logic [7:0] pend_val;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge and issue the expected token.
    task automatic drive(input bit rst, input bit wv, input bit ev, input bit en,
                         input logic [7:0] d, input logic [1:0] c);
        @(posedge CLK);
        #1;
        RST_N             = ~rst;
        IN_WRITE_VALID    = wv;
        IN_EN_WRITE_VALID = ev;
        IN_EN_WRITE       = en;
        IN_WRITE          = d;
        OUT_READ_CONSUMED = c;
        if (!rst && wv && ev && tq.size() < DEPTH) begin
            pend     = 1'b1;
            pend_val = en ? d : mlast;
            rq0.push_back(pend_val);
            rq1.push_back(pend_val);
        end else begin
            pend = 1'b0;
        end
    endtask

    // Monitor: compare mid-cycle, then advance the model across the coming edge.
    initial begin
        logic [1:0] fire;
        logic [7:0] expv;
        bit         ev;
        bit         iv;
        bit         retire;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                tq.delete();  tq.push_back(INIT);
                rq0.delete(); rq0.push_back(INIT);
                rq1.delete(); rq1.push_back(INIT);
                mlast     = INIT;
                mdone     = 2'b00;
                init_done = 1'b1;
            end else if (init_done) begin
                iv = IN_WRITE_VALID && IN_EN_WRITE_VALID;
                chk("wr_consumed", {31'd0, IN_WRITE_CONSUMED}, (iv && tq.size() >= DEPTH) ? 32'd0 : 32'd1);
                chk("en_consumed", {31'd0, IN_EN_WRITE_CONSUMED}, (iv && tq.size() >= DEPTH) ? 32'd0 : 32'd1);
                chk("count", {29'd0, COUNT}, tq.size());
                expv = (tq.size() == 0) ? mlast : tq[0];
                chk("out_read", {24'd0, OUT_READ}, {24'd0, expv});
                fire = 2'b00;
                for (int r = 0; r < READERS; r++) begin
                    ev = (tq.size() != 0) && !mdone[r];
                    chk(r == 0 ? "valid0" : "valid1", {31'd0, OUT_READ_VALID[r]}, {31'd0, ev});
                    fire[r] = ev && OUT_READ_CONSUMED[r];
                end
                if (fire[0]) begin
                    if (rq0.size() == 0) chk("sb0_empty", 32'd1, 32'd0);
                    else chk("sb0_data", {24'd0, OUT_READ}, {24'd0, rq0.pop_front()});
                end
                if (fire[1]) begin
                    if (rq1.size() == 0) chk("sb1_empty", 32'd1, 32'd0);
                    else chk("sb1_data", {24'd0, OUT_READ}, {24'd0, rq1.pop_front()});
                end
                retire = (tq.size() != 0) && ((mdone | fire) == 2'b11);
                if (retire) begin
                    void'(tq.pop_front());
                    mdone = 2'b00;
                end else begin
                    mdone = mdone | fire;
                end
                if (pend) begin
                    tq.push_back(pend_val);
                    mlast = pend_val;
                end
            end
        end
    end

    initial begin
        RST_N = 1'b0; IN_WRITE = 8'h00; IN_WRITE_VALID = 1'b0; IN_EN_WRITE = 1'b0;
        IN_EN_WRITE_VALID = 1'b0; OUT_READ_CONSUMED = 2'b00;
        drive(1, 0, 0, 0, 8'h00, 2'b00);
        drive(0, 0, 0, 0, 8'h00, 2'b00);
        // Fill to full, then hold 0x44 until skewed readers retire the head.
        drive(0, 1, 1, 1, 8'h11, 2'b00);
        drive(0, 1, 1, 1, 8'h22, 2'b00);
        drive(0, 1, 1, 1, 8'h33, 2'b00);
        drive(0, 1, 1, 1, 8'h44, 2'b00);
        drive(0, 1, 1, 1, 8'h44, 2'b01);
        drive(0, 1, 1, 1, 8'h44, 2'b00);
        drive(0, 1, 1, 1, 8'h44, 2'b10);
        drive(0, 1, 1, 1, 8'h44, 2'b00);
        repeat (6) drive(0, 0, 0, 0, 8'h00, 2'b11);
        drive(0, 0, 0, 0, 8'h00, 2'b00);
        // Enable-low token repeats the previous value.
        drive(0, 1, 1, 1, 8'h77, 2'b00);
        drive(0, 1, 1, 0, 8'h99, 2'b00);
        repeat (4) drive(0, 0, 0, 0, 8'h00, 2'b11);
        // Full with retire blocks the write; at three, write plus retire holds the count.
        repeat (4) drive(0, 1, 1, 1, 8'hA0, 2'b00);
        drive(0, 1, 1, 1, 8'hA1, 2'b11);
        drive(0, 1, 1, 1, 8'hA2, 2'b11);
        drive(0, 0, 0, 0, 8'h00, 2'b00);
        // Mid-operation reset with one reader part-way through the head.
        drive(0, 0, 0, 0, 8'h00, 2'b01);
        drive(1, 1, 1, 1, 8'hEE, 2'b00);
        drive(0, 0, 0, 0, 8'h00, 2'b00);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, 8'($urandom),
                  2'($urandom));
        end
        repeat (3) drive(0, 0, 0, 0, 8'h00, 2'b00);
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/li_reg_multi.md
# li_reg_multi

Latency-insensitive register with a token queue of configurable depth and independent fan-out to several readers. It generalises the two-slot LI register: the producer can run up to DEPTH tokens ahead of the slowest consumer. Each token carries a data value plus a write enable, and is resolved to a register value on entry. The head token is retired only after every reader has consumed it. It sits between LI-wrapped producer and consumer partitions wherever one register value feeds multiple LI readers.

## Interface
- WIDTH, 8: data width, ≥1.
- INIT, 0: register value after reset.
- DEPTH, 2: token slots including the current head, 2..16, not restricted to a power of two.
- READERS, 2: number of reader channels, 1..8.

- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low; clock CLK.
- IN_WRITE  in  WIDTH  write data.
- IN_WRITE_VALID  in  1  write data token present.
- IN_WRITE_CONSUMED  out  1  write data token accepted.
- IN_EN_WRITE  in  1  write enable for the token.
- IN_EN_WRITE_VALID  in  1  enable token present.
- IN_EN_WRITE_CONSUMED  out  1  enable token accepted.
- OUT_READ  out  WIDTH  current register value, shared by all readers.
- OUT_READ_VALID  out  READERS  per-reader head token available.
- OUT_READ_CONSUMED  in  READERS  per-reader consume.
- COUNT  out  $clog2(DEPTH+1)  tokens held (0..DEPTH).

## Operation
**Storage and state**
- Circular buffer mem[DEPTH] holds resolved data values.
- head and tail pointers wrap from DEPTH-1 to 0.
- COUNT register.
- last_data register holds the resolved value of the most recently enqueued token.
- done[READERS] holds per-reader consumed flags for the head token.

**Input**
- inpValid = IN_WRITE_VALID & IN_EN_WRITE_VALID.
- IN_WRITE_CONSUMED = IN_EN_WRITE_CONSUMED = inpValid ? (COUNT < DEPTH) : 1.
- Both CONSUMED outputs are always identical.
- There is no combinational path from OUT_READ_CONSUMED to either CONSUMED output.
- Enqueue happens when inpValid and COUNT < DEPTH.
- Resolved value = IN_EN_WRITE ? IN_WRITE : last_data.
- On enqueue, the resolved value is written to mem[tail] and to last_data, and tail advances.
- A token with enable = 0 is still a token: it occupies a slot and must be consumed by every reader.

**Output**
- OUT_READ = (COUNT == 0) ? last_data : mem[head].
- OUT_READ_VALID[r] = (COUNT != 0) & !done[r].
- A reader fires when OUT_READ_VALID[r] & OUT_READ_CONSUMED[r].
- Retire condition: COUNT != 0 and, for every r, done[r] or reader r fires.
- On retire, head advances and all done bits clear.
- Otherwise, done[r] is set for each reader that fires.
- OUT_READ_CONSUMED[r] is ignored while OUT_READ_VALID[r] = 0.

**Simultaneous events**
- Enqueue and retire in the same cycle: COUNT is unchanged and both pointers advance.
- Enqueue with COUNT = 0: the token becomes the head on the next cycle.
- Enqueue is blocked when COUNT = DEPTH, even if a retire occurs that same cycle.

**Reset** (also mid-operation)
- mem[0] = INIT, head = 0, tail = 1 mod DEPTH, COUNT = 1, last_data = INIT, done = 0.
- Resulting outputs: OUT_READ = INIT, OUT_READ_VALID = all ones, COUNT = 1, both CONSUMED outputs = 1 while no input is valid.
- Any partially consumed head token and all queued tokens are discarded.

## Timing
- Enqueue-to-visible latency is 1 cycle when COUNT was 0, or when COUNT was 1 and the head retired in the same cycle. Otherwise the token waits behind older tokens.
- A reader's VALID drops the cycle after it fires and stays low until the head retires.
- Back-to-back throughput is one token per cycle, provided all readers consume every cycle.
- CONSUMED outputs depend only on the input valids and registered COUNT.
- OUT_READ_VALID and OUT_READ depend only on registered state.

## Test plan
1. **Reset:** after RST_N = 0 for 1 cycle with INIT = 0x5A → OUT_READ = 0x5A, OUT_READ_VALID = 2'b11, COUNT = 1.
2. **Fill to full** (DEPTH = 4, WIDTH = 8, readers idle): write 0x11, 0x22, 0x33 with en = 1 on consecutive cycles → COUNT reaches 4, OUT_READ stays 0x5A. Then offer 0x44 → CONSUMED = 0, and 0x44 is held until a retire occurs.
3. **Skewed readers:** reader0 consumes at cycle t, reader1 at t+2 → VALID = 2'b10 at t+1..t+2; retire at t+2; at t+3 VALID = 2'b11 and OUT_READ = 0x11.
4. **Enable-low token:** write 0x77 with en = 1, then 0x99 with en = 0 → both readers see 0x77 twice, and COUNT counts two tokens.
5. **Drain and concurrency:** drain to COUNT = 0 → VALID = 0 and OUT_READ holds the last value. At COUNT = 4, a write plus full retire in one cycle → write blocked, COUNT = 3. At COUNT = 3, a write plus retire → COUNT stays 3.
6. **Mid-operation reset:** with COUNT = 3 and done = 2'b01, assert RST_N = 0 → next cycle OUT_READ = INIT, COUNT = 1, VALID = 2'b11.
